rot_btn_input_conditioner: RTL

Input front end for the single-cycle MCU with LCD. It synchronizes and debounces the raw push-button and rotary-encoder pins, and decodes full quadrature detents into clockwise and counter-clockwise events. It also detects button presses. Events reach the MCU through a one-entry valid/ack holding register. This block sits directly upstream of the MCU's `btn`/`rot_a`/`rot_b` consumer logic.

---
 rtl/rot_btn_input_conditioner_pkg.sv | 25 ++
 rtl/rot_btn_input_conditioner_if.sv | 31 +++
 rtl/rot_btn_input_conditioner_debounce.sv | 56 +++++
 rtl/rot_btn_input_conditioner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rot_btn_input_conditioner_pkg.sv
// rot_input_pkg: shared definitions for the rotary/button input conditioner.
//   - default debounce length
//   - event codes carried on evt_code
//   - quadrature decoder state encoding
// Optional feature macro used by the slice: ROT_POS_ACCUM_EN (detent accumulator).
package rot_input_pkg;

  localparam int unsigned DEB_CYCLES_DEFAULT = 50000;

  localparam logic [1:0] EVT_NONE  = 2'b00;
  localparam logic [1:0] EVT_CW    = 2'b01;
  localparam logic [1:0] EVT_CCW   = 2'b10;
  localparam logic [1:0] EVT_PRESS = 2'b11;

  typedef enum logic [2:0] {
    Q_IDLE,
    Q_CW1,
    Q_CW2,
    Q_CW3,
    Q_CCW1,
    Q_CCW2,
    Q_CCW3
  } quad_state_t;

endpackage

// File: rtl/rot_btn_input_conditioner_if.sv
// rot_btn_input_conditioner_if: event hand-off between the input conditioner
// and the MCU.
//   ack       : MCU consumes the held event
//   evt_valid : holding register contains an event
//   evt_code  : event code (00 when evt_valid=0)
//   overrun   : sticky dropped-event flag
//   btn_level : debounced button level
//   position  : signed detent accumulator (only with ROT_POS_ACCUM_EN)
// master = conditioner (event source), slave = MCU (event sink).
interface rot_btn_input_conditioner_if;
  logic       ack;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       overrun;
  logic       btn_level;
`ifdef ROT_POS_ACCUM_EN
  logic [7:0] position;
`endif

`ifdef ROT_POS_ACCUM_EN
  modport master (input ack, output evt_valid, output evt_code, output overrun,
                  output btn_level, output position);
  modport slave  (output ack, input evt_valid, input evt_code, input overrun,
                  input btn_level, input position);
`else
  modport master (input ack, output evt_valid, output evt_code, output overrun,
                  output btn_level);
  modport slave  (output ack, input evt_valid, input evt_code, input overrun,
                  input btn_level);
`endif
endinterface

// File: rtl/rot_btn_input_conditioner_debounce.sv
// input_debounce: 2-flop synchronizer followed by a counting debouncer.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   raw_i    : raw asynchronous pin
//   stable_o : debounced level
// The stable level flips only after the synced input has differed from it for
// DEB_CYCLES consecutive clocks.
module input_debounce
  import rot_input_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             synced;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign synced = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/rot_btn_input_conditioner.sv
// rot_btn_input_conditioner: MCU input front end.
//   clk_in        : system clock (rising edge)
//   nClear        : asynchronous active-low reset
//   btn           : raw push-button (active high)
//   rot_a, rot_b  : raw quadrature encoder channels
//   evt (master)  : ack / evt_valid / evt_code / overrun / btn_level [/ position]
// Debounces all three pins, decodes full quadrature detents into CW/CCW,
// detects button presses and presents events through a one-entry valid/ack
// holding register. Define ROT_POS_ACCUM_EN to add the 8-bit signed detent
// accumulator on evt.position.
module rot_btn_input_conditioner
  import rot_input_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk_in,
  input  logic                          nClear,
  input  logic                          btn,
  input  logic                          rot_a,
  input  logic                          rot_b,
  rot_btn_input_conditioner_if.master   evt
);

  logic a_deb, b_deb, btn_deb;
  logic [1:0] ab;

  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_a (
    .clk_i(clk_in), .rst_ni(nClear), .raw_i(rot_a), .stable_o(a_deb)
  );
  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_b (
    .clk_i(clk_in), .rst_ni(nClear), .raw_i(rot_b), .stable_o(b_deb)
  );
  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_btn (
    .clk_i(clk_in), .rst_ni(nClear), .raw_i(btn), .stable_o(btn_deb)
  );

  assign ab = {a_deb, b_deb};

  // Quadrature decoder
  quad_state_t state_q, state_d;
  logic        cw_d, ccw_d;
  logic        cw_q, ccw_q;

  always_ff @(posedge clk_in or negedge nClear) begin
    if (!nClear) begin
      state_q <= Q_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Unlisted inputs (including two-bit jumps) hold the current state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Q_IDLE: begin
        if (ab == 2'b10)      state_d = Q_CW1;
        else if (ab == 2'b01) state_d = Q_CCW1;
      end
      Q_CW1: begin
        if (ab == 2'b11)      state_d = Q_CW2;
        else if (ab == 2'b00) state_d = Q_IDLE;
      end
      Q_CW2: begin
        if (ab == 2'b01)      state_d = Q_CW3;
        else if (ab == 2'b10) state_d = Q_CW1;
      end
      Q_CW3: begin
        if (ab == 2'b00)      state_d = Q_IDLE;
        else if (ab == 2'b11) state_d = Q_CW2;
      end
      Q_CCW1: begin
        if (ab == 2'b11)      state_d = Q_CCW2;
        else if (ab == 2'b00) state_d = Q_IDLE;
      end
      Q_CCW2: begin
        if (ab == 2'b10)      state_d = Q_CCW3;
        else if (ab == 2'b01) state_d = Q_CCW1;
      end
      Q_CCW3: begin
        if (ab == 2'b00)      state_d = Q_IDLE;
        else if (ab == 2'b11) state_d = Q_CCW2;
      end
      default: state_d = Q_IDLE;
    endcase
  end

  always_comb begin
    cw_d  = 1'b0;
    ccw_d = 1'b0;
    if ((state_q == Q_CW3) && (ab == 2'b00))  cw_d  = 1'b1;
    if ((state_q == Q_CCW3) && (ab == 2'b00)) ccw_d = 1'b1;
  end

  // Registered event pulses: decoder emits and button rising edge
  logic btn_prev_q, press_q;

  always_ff @(posedge clk_in or negedge nClear) begin
    if (!nClear) begin
      cw_q       <= 1'b0;
      ccw_q      <= 1'b0;
      btn_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      cw_q       <= cw_d;
      ccw_q      <= ccw_d;
      btn_prev_q <= btn_deb;
      press_q    <= btn_deb & ~btn_prev_q;
    end
  end

  // Holding register
  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic       overrun_q, overrun_d;
  logic       rot_evt, new_evt, can_load, drop;
  logic [1:0] new_code;

  assign rot_evt  = cw_q | ccw_q;
  assign new_evt  = press_q | rot_evt;
  assign new_code = press_q ? EVT_PRESS : (cw_q ? EVT_CW : EVT_CCW);
  assign can_load = ~valid_q | evt.ack;
  // A rotation coinciding with a press loses to the press and counts as dropped.
  assign drop     = (new_evt & ~can_load) | (press_q & rot_evt);

  always_comb begin
    valid_d   = valid_q;
    code_d    = code_q;
    overrun_d = overrun_q;
    if (new_evt && can_load) begin
      valid_d = 1'b1;
      code_d  = new_code;
    end else if (valid_q && evt.ack) begin
      valid_d = 1'b0;
      code_d  = EVT_NONE;
    end
    if (drop)          overrun_d = 1'b1;
    else if (evt.ack)  overrun_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge nClear) begin
    if (!nClear) begin
      valid_q   <= 1'b0;
      code_q    <= EVT_NONE;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_code  = code_q;
  assign evt.overrun   = overrun_q;
  assign evt.btn_level = btn_deb;

`ifdef ROT_POS_ACCUM_EN
  // Counts every decoded detent, independent of holding-register drops.
  logic [7:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (cw_q)       pos_d = pos_q + 8'd1;
    else if (ccw_q) pos_d = pos_q - 8'd1;
  end

  always_ff @(posedge clk_in or negedge nClear) begin
    if (!nClear) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign evt.position = pos_q;
`endif

endmodule
